// File: rtl/coverfloat_vector_sequencer.sv
// Cover-vector sequencer: buffers packed vectors from a stream source in a
// small FIFO, unpacks each one into registered fields for the coverage
// sampler, counts sampler handshakes and tracks end-of-stream.
//
// state | meaning
// IDLE  | waiting for start; input and output stage inactive
// RUN   | accepting vectors and feeding the sampler
// DRAIN | final vector accepted; emptying FIFO and output stage
// DONE  | stream fully consumed; held until reset
module coverfloat_vector_sequencer #(
  parameter int DEPTH  = 4,
  parameter int OP_W   = 32,
  parameter int RM_W   = 8,
  parameter int OPND_W = 128,
  parameter int FMT_W  = 8,
  parameter int EXC_W  = 8,
  parameter int IX_W   = 32,
  parameter int IM_W   = 192,
  localparam int VEC_W = OP_W + RM_W + 4*OPND_W + 2*FMT_W + EXC_W + 3 + 1 + IX_W + IM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VEC_W-1:0]  in_vector,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   op,
  output logic [RM_W-1:0]   rm,
  output logic [OPND_W-1:0] a,
  output logic [OPND_W-1:0] b,
  output logic [OPND_W-1:0] c,
  output logic [FMT_W-1:0]  operandFmt,
  output logic [OPND_W-1:0] result,
  output logic [FMT_W-1:0]  resultFmt,
  output logic [EXC_W-1:0]  exceptionBits,
  output logic              intermS,
  output logic [IX_W-1:0]   intermX,
  output logic [IM_W-1:0]   intermM,
  output logic [31:0]       vectornum,
  output logic              cnt_wrap,
  output logic              discard_err,
  output logic              busy,
  output logic              done
);

  localparam int AW    = $clog2(DEPTH);
  // Field LSB positions inside the packed vector (intermM sits at bit 0)
  localparam int L_IX  = IM_W;
  localparam int L_IS  = L_IX + IX_W;
  localparam int L_DIS = L_IS + 1;
  localparam int L_EXC = L_DIS + 3;
  localparam int L_RF  = L_EXC + EXC_W;
  localparam int L_RES = L_RF + FMT_W;
  localparam int L_OF  = L_RES + OPND_W;
  localparam int L_C   = L_OF + FMT_W;
  localparam int L_B   = L_C + OPND_W;
  localparam int L_A   = L_B + OPND_W;
  localparam int L_RM  = L_A + OPND_W;
  localparam int L_OP  = L_RM + RM_W;
  localparam int HI_W  = VEC_W - L_EXC;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [VEC_W-1:0]    r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_count;
  logic                r_out_valid;
  logic [HI_W-1:0]     r_hi;
  logic [L_DIS-1:0]    r_lo;
  logic [31:0]         r_vectornum;
  logic                r_cnt_wrap;
  logic                r_discard_err;

  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_load;
  logic                w_hs;
  logic                w_active;
  logic [VEC_W-1:0]    w_head;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == (AW+1)'(DEPTH));
  assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign in_ready = (r_state == S_RUN) && !w_full;
  assign w_push   = in_valid && in_ready;
  // Load decision uses the pre-edge count, so a fresh push never bypasses.
  assign w_load   = en && !w_empty && (!r_out_valid || out_ready) && w_active;
  assign w_hs     = r_out_valid && out_ready;
  assign w_head   = r_mem[r_rd_ptr];

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_push && in_last) w_next = S_DRAIN;
      S_DRAIN: if (w_empty && !r_out_valid) w_next = S_DONE;
      S_DONE:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_load)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_load) r_count <= r_count - (AW+1)'(1);
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= in_vector;
  end

  // Output stage: pop and unpack on load, drop valid on a bare handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_hi        <= w_head[VEC_W-1:L_EXC];
      r_lo        <= w_head[L_DIS-1:0];
    end else if (w_hs) begin
      r_out_valid <= 1'b0;
    end
  end

  // Handshake counter and sticky status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vectornum   <= '0;
      r_cnt_wrap    <= 1'b0;
      r_discard_err <= 1'b0;
    end else begin
      if (w_hs) begin
        r_vectornum <= r_vectornum + 32'd1;
        if (r_vectornum == '1) r_cnt_wrap <= 1'b1;
      end
      if (w_load && (w_head[L_DIS +: 3] != 3'b000)) r_discard_err <= 1'b1;
    end
  end

  assign out_valid     = r_out_valid;
  assign op            = r_hi[L_OP  - L_EXC +: OP_W];
  assign rm            = r_hi[L_RM  - L_EXC +: RM_W];
  assign a             = r_hi[L_A   - L_EXC +: OPND_W];
  assign b             = r_hi[L_B   - L_EXC +: OPND_W];
  assign c             = r_hi[L_C   - L_EXC +: OPND_W];
  assign operandFmt    = r_hi[L_OF  - L_EXC +: FMT_W];
  assign result        = r_hi[L_RES - L_EXC +: OPND_W];
  assign resultFmt     = r_hi[L_RF  - L_EXC +: FMT_W];
  assign exceptionBits = r_hi[0 +: EXC_W];
  assign intermS       = r_lo[L_IS];
  assign intermX       = r_lo[L_IX +: IX_W];
  assign intermM       = r_lo[0 +: IM_W];
  assign vectornum     = r_vectornum;
  assign cnt_wrap      = r_cnt_wrap;
  assign discard_err   = r_discard_err;
  assign busy          = w_active;
  assign done          = (r_state == S_DONE);

endmodule

// File: tb/tb_coverfloat_vector_sequencer.sv
// Self-checking bench for coverfloat_vector_sequencer: directed scenarios
// followed by a randomized phase, all compared against a queue-based model.
module tb_coverfloat_vector_sequencer;

  localparam int DEPTH = 4;
  localparam int VEC_W = 804;
  localparam int DIS   = 225;   // discard[2:0] LSB position
  localparam int OPL   = 772;   // op LSB position
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic              clk = 1'b0;
  logic              reset, start, en, in_valid, in_last, out_ready;
  logic              in_ready, out_valid;
  logic [VEC_W-1:0]  in_vector;
  logic [31:0]       op;
  logic [7:0]        rm, operandFmt, resultFmt, exceptionBits;
  logic [127:0]      a, b, c, result;
  logic              intermS;
  logic [31:0]       intermX;
  logic [191:0]      intermM;
  logic [31:0]       vectornum;
  logic              cnt_wrap, discard_err, busy, done;

  coverfloat_vector_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .en(en),
    .in_valid(in_valid), .in_ready(in_ready), .in_vector(in_vector), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .rm(rm), .a(a), .b(b), .c(c), .operandFmt(operandFmt),
    .result(result), .resultFmt(resultFmt), .exceptionBits(exceptionBits),
    .intermS(intermS), .intermX(intermX), .intermM(intermM),
    .vectornum(vectornum), .cnt_wrap(cnt_wrap), .discard_err(discard_err),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  logic [VEC_W-1:0] mq [$];
  int               m_state;
  logic             m_ov;
  logic [VEC_W-1:0] m_vec;
  logic [31:0]      m_vn;
  logic             m_wrap, m_derr;

  task automatic chk(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] rvec(input logic [31:0] opv, input logic [2:0] dis);
    logic [VEC_W-1:0] v;
    v = '0;
    for (int i = 0; i < VEC_W/32; i++) v[i*32 +: 32] = $urandom();
    v[VEC_W-1:800] = 4'($urandom());
    v[OPL +: 32] = opv;
    v[DIS +: 3]  = dis;
    return v;
  endfunction

  task automatic model_step();
    int   sz;
    logic push, load, hs;
    if (reset) begin
      mq.delete();
      m_state = M_IDLE; m_ov = 1'b0; m_vec = '0;
      m_vn = '0; m_wrap = 1'b0; m_derr = 1'b0;
      return;
    end
    sz   = mq.size();
    push = in_valid && (m_state == M_RUN) && (sz < DEPTH);
    load = en && (sz > 0) && (!m_ov || out_ready) && (m_state == M_RUN || m_state == M_DRAIN);
    hs   = m_ov && out_ready;
    if (m_state == M_IDLE && start) m_state = M_RUN;
    else if (m_state == M_RUN && push && in_last) m_state = M_DRAIN;
    else if (m_state == M_DRAIN && sz == 0 && !m_ov) m_state = M_DONE;
    if (hs) begin
      if (m_vn == 32'hFFFF_FFFF) m_wrap = 1'b1;
      m_vn = m_vn + 32'd1;
    end
    if (load) begin
      m_vec = mq.pop_front();
      m_ov  = 1'b1;
      if (m_vec[DIS +: 3] != 3'b000) m_derr = 1'b1;
    end else if (hs) begin
      m_ov = 1'b0;
    end
    if (push) mq.push_back(in_vector);
  endtask

  task automatic check_all();
    chk("in_ready",    VEC_W'(in_ready),    VEC_W'(m_state == M_RUN && mq.size() < DEPTH));
    chk("out_valid",   VEC_W'(out_valid),   VEC_W'(m_ov));
    chk("fields",      VEC_W'({op, rm, a, b, c, operandFmt, result, resultFmt, exceptionBits,
                               intermS, intermX, intermM}),
                       VEC_W'({m_vec[VEC_W-1:DIS+3], m_vec[DIS-1:0]}));
    chk("vectornum",   VEC_W'(vectornum),   VEC_W'(m_vn));
    chk("cnt_wrap",    VEC_W'(cnt_wrap),    VEC_W'(m_wrap));
    chk("discard_err", VEC_W'(discard_err), VEC_W'(m_derr));
    chk("busy",        VEC_W'(busy),        VEC_W'(m_state == M_RUN || m_state == M_DRAIN));
    chk("done",        VEC_W'(done),        VEC_W'(m_state == M_DONE));
  endtask

  task automatic cyc(input logic rs, input logic st, input logic e, input logic iv,
                     input logic il, input logic ordy, input logic [VEC_W-1:0] v);
    reset = rs; start = st; en = e; in_valid = iv; in_last = il; out_ready = ordy; in_vector = v;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; en = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; in_vector = '0;
    m_state = M_IDLE; m_ov = 1'b0; m_vec = '0; m_vn = '0; m_wrap = 1'b0; m_derr = 1'b0;

    // T1: three vectors straight through
    cyc(1, 0, 1, 0, 0, 1, '0);
    cyc(0, 1, 1, 0, 0, 1, '0);
    for (int i = 1; i <= 3; i++) cyc(0, 0, 1, 1, 0, 1, rvec(32'(i), 3'b000));
    repeat (4) cyc(0, 0, 1, 0, 0, 1, '0);
    chk("t1_vectornum", VEC_W'(vectornum), VEC_W'(32'd3));
    chk("t1_last_op",   VEC_W'(op),        VEC_W'(32'd3));

    // T2: sampler stalled, FIFO plus output stage fill, then drain
    cyc(1, 0, 1, 0, 0, 0, '0);
    cyc(0, 1, 1, 0, 0, 0, '0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 1, 0, 0, rvec(32'(10 + i), 3'b000));
    chk("t2_in_ready_full", VEC_W'(in_ready), VEC_W'(1'b0));
    repeat (7) cyc(0, 0, 1, 0, 0, 1, '0);
    chk("t2_vectornum", VEC_W'(vectornum), VEC_W'(32'd5));

    // T3: in_last on the second vector, extra input ignored
    cyc(1, 0, 1, 0, 0, 1, '0);
    cyc(0, 1, 1, 0, 0, 1, '0);
    cyc(0, 0, 1, 1, 0, 1, rvec(32'd21, 3'b000));
    cyc(0, 0, 1, 1, 1, 1, rvec(32'd22, 3'b000));
    for (int k = 0; k < 10 && !done; k++) cyc(0, 0, 1, 1, 0, 1, rvec(32'd23, 3'b000));
    chk("t3_done",      VEC_W'(done),      VEC_W'(1'b1));
    chk("t3_vectornum", VEC_W'(vectornum), VEC_W'(32'd2));
    chk("t3_last_op",   VEC_W'(op),        VEC_W'(32'd22));

    // T4: output stage held by en=0, then released
    cyc(1, 0, 0, 0, 0, 1, '0);
    cyc(0, 1, 0, 0, 0, 1, '0);
    cyc(0, 0, 0, 1, 0, 1, rvec(32'd31, 3'b000));
    cyc(0, 0, 0, 1, 0, 1, rvec(32'd32, 3'b000));
    repeat (3) cyc(0, 0, 0, 0, 0, 1, '0);
    chk("t4_hold_out_valid", VEC_W'(out_valid), VEC_W'(1'b0));
    repeat (4) cyc(0, 0, 1, 0, 0, 1, '0);
    chk("t4_vectornum", VEC_W'(vectornum), VEC_W'(32'd2));

    // T5: nonzero discard bits set the sticky flag
    cyc(1, 0, 1, 0, 0, 1, '0);
    cyc(0, 1, 1, 0, 0, 1, '0);
    cyc(0, 0, 1, 1, 0, 1, rvec(32'd41, 3'b101));
    repeat (3) cyc(0, 0, 1, 0, 0, 1, '0);
    chk("t5_discard_err", VEC_W'(discard_err), VEC_W'(1'b1));
    cyc(0, 0, 1, 1, 0, 1, rvec(32'd42, 3'b000));
    repeat (2) cyc(0, 0, 1, 0, 0, 1, '0);
    chk("t5_discard_sticky", VEC_W'(discard_err), VEC_W'(1'b1));
    cyc(1, 0, 1, 0, 0, 1, '0);
    chk("t5_discard_reset", VEC_W'(discard_err), VEC_W'(1'b0));

    // T6: counter wrap from a preloaded value, then reset mid-DRAIN
    cyc(0, 1, 1, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0, 0, rvec(32'(51 + i), 3'b000));
    force dut.r_vectornum = 32'hFFFF_FFFE;
    m_vn = 32'hFFFF_FFFE;
    cyc(0, 0, 1, 0, 0, 0, '0);
    release dut.r_vectornum;
    cyc(0, 0, 1, 0, 0, 1, '0);
    cyc(0, 0, 1, 0, 0, 1, '0);
    chk("t6_wrap_value", VEC_W'(vectornum), VEC_W'(32'd0));
    chk("t6_cnt_wrap",   VEC_W'(cnt_wrap),  VEC_W'(1'b1));
    cyc(0, 0, 1, 1, 1, 0, rvec(32'd60, 3'b000));
    chk("t6_drain_busy", VEC_W'(busy),      VEC_W'(1'b1));
    chk("t6_drain_ov",   VEC_W'(out_valid), VEC_W'(1'b1));
    cyc(1, 0, 1, 0, 0, 0, '0);
    chk("t6_rst_out_valid", VEC_W'(out_valid), VEC_W'(1'b0));
    chk("t6_rst_vectornum", VEC_W'(vectornum), VEC_W'(32'd0));
    chk("t6_rst_idle",      VEC_W'({busy, done, cnt_wrap}), VEC_W'(3'b000));

    // Randomized phase
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 3) != 0), 1'($urandom()), ($urandom_range(0, 19) == 0),
          1'($urandom()),
          rvec($urandom(), ($urandom_range(0, 7) == 0) ? 3'($urandom()) : 3'b000));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
